// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
// Holds the FSM state encoding, the PC increment, the NOP word shown
// before the first fetch completes, and the default reset vector.
package pc_ctrl_pkg;

  localparam logic [31:0] PC_INC               = 32'd4;
  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE = 3'd0;
  localparam fetch_state_t ST_REQ  = 3'd1;
  localparam fetch_state_t ST_WAIT = 3'd2;
  localparam fetch_state_t ST_HOLD = 3'd3;
  localparam fetch_state_t ST_HALT = 3'd4;

  // Instructions are word aligned; any low address bit set is an error.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_pc_adder.sv
// Sequential PC increment for the fetch controller.
// Ports:
//   pc_i      : current program counter
//   pc_next_o : pc_i + PC_INC, wrapping modulo 2^32 (carry discarded)
module PC_Adder
  import pc_ctrl_pkg::*;
(
  input  logic [31:0] pc_i,
  output logic [31:0] pc_next_o
);

  assign pc_next_o = pc_i + PC_INC;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller with at most one fetch outstanding.
// Issues requests to instruction memory, holds the returned word for the
// consumer until it is taken, and follows branch/jump redirects. A
// misaligned redirect latches misalign_err and parks the FSM until reset.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   stall              : consumer not ready, keep presenting instr
//   redirect_valid/... : taken branch/jump and its target address
//   imem_req/addr/gnt  : request handshake to instruction memory
//   imem_rvalid/rdata  : read response from instruction memory
//   instr_valid/instr/instr_pc : instruction presented to the consumer
//   misalign_err       : sticky misaligned-redirect flag
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign_err
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         kill_q, kill_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  pc_plus4;
  logic         redirect_ok;
  logic         redirect_bad;

  PC_Adder u_pc_adder (
    .pc_i      (pc_q),
    .pc_next_o (pc_plus4)
  );

  assign redirect_ok  = redirect_valid && !is_misaligned(redirect_target);
  assign redirect_bad = redirect_valid &&  is_misaligned(redirect_target);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    kill_d     = kill_q;
    misalign_d = misalign_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        pc_d    = RESET_VECTOR;
        kill_d  = 1'b0;
      end

      ST_REQ: begin
        if (redirect_bad) begin
          state_d    = ST_HALT;
          misalign_d = 1'b1;
          kill_d     = 1'b0;
        end else if (redirect_ok) begin
          pc_d = redirect_target;
          // A fetch accepted in the redirect cycle still returns data;
          // wait for it but mark it for discard.
          if (imem_gnt) begin
            state_d = ST_WAIT;
            kill_d  = 1'b1;
          end
        end else if (imem_gnt) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redirect_bad) begin
          state_d    = ST_HALT;
          misalign_d = 1'b1;
          kill_d     = 1'b0;
        end else if (redirect_ok) begin
          pc_d = redirect_target;
          // Response arriving in the redirect cycle is dropped right away;
          // otherwise remember to drop it when it shows up.
          if (imem_rvalid) begin
            state_d = ST_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill_q) begin
            state_d = ST_REQ;
            kill_d  = 1'b0;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            state_d    = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (redirect_bad) begin
          state_d    = ST_HALT;
          misalign_d = 1'b1;
        end else if (redirect_ok) begin
          pc_d    = redirect_target;
          state_d = ST_REQ;
        end else if (!stall) begin
          pc_d    = pc_plus4;
          state_d = ST_REQ;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_VECTOR;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_VECTOR;
      kill_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      kill_q     <= kill_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req     = (state_q == ST_REQ);
  assign imem_addr    = pc_q;
  assign instr_valid  = (state_q == ST_HOLD);
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: memory responder, program-flow reference model
// feeding an expected-PC queue, and an independent monitor that checks each
// instruction the DUT presents.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign_err;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .misalign_err(misalign_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory contents ----------------
  logic const_data = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (const_data) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // ---------------- memory responder ----------------
  logic        fixed_mode = 1'b1;
  int          fixed_delay = 0;
  logic        block_en = 1'b0;
  logic [31:0] block_addr = 32'h0;
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr_l = 32'h0;
  logic        prev_req = 1'b0, prev_gnt = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] gnt_log[$];

  always @(negedge clk) begin
    // redirect_valid still holds the value driven for the previous edge here
    if (!rst && prev_req && !prev_gnt && imem_req && !redirect_valid)
      check("addr_stable", imem_addr, prev_addr);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr_l);
        mem_busy    = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    if (imem_req && !mem_busy && !(block_en && imem_addr == block_addr) &&
        (fixed_mode || $urandom_range(0, 9) < 6)) begin
      imem_gnt   = 1'b1;
      mem_busy   = 1'b1;
      mem_addr_l = imem_addr;
      mem_cnt    = fixed_mode ? fixed_delay : int'($urandom_range(0, 2));
      gnt_log.push_back(imem_addr);
    end
    prev_req  = imem_req;
    prev_gnt  = imem_gnt;
    prev_addr = imem_addr;
  end

  // ---------------- reference model state ----------------
  logic [31:0] exp_q[$];
  logic        m_halted = 1'b0;
  logic        m_idle = 1'b0;
  logic [31:0] m_last = 32'h0;

  // ---------------- monitor ----------------
  logic        prev_valid = 1'b0;
  logic [31:0] hold_pc = 32'h0, hold_instr = 32'h0, mon_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      check("misalign_err", {31'b0, misalign_err}, {31'b0, m_halted});
      if (m_halted) begin
        check("halt_req", {31'b0, imem_req}, 32'd0);
        check("halt_valid", {31'b0, instr_valid}, 32'd0);
      end
      if (instr_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc %h with none expected", instr_pc);
          hold_pc    = instr_pc;
          hold_instr = instr;
        end else begin
          mon_e = exp_q.pop_front();
          check("instr_pc", instr_pc, mon_e);
          check("instr", instr, mem_word(mon_e));
          $display("instr pc=%h instr=%h expected_pc=%h", instr_pc, instr, mon_e);
          m_last     = mon_e;
          hold_pc    = mon_e;
          hold_instr = mem_word(mon_e);
        end
      end else if (instr_valid) begin
        check("hold_pc", instr_pc, hold_pc);
        check("hold_instr", instr, hold_instr);
      end
      prev_valid = instr_valid;
    end
  end

  // ---------------- stimulus + model update ----------------
  // Called at negedge+1; applies inputs for the next edge, updates the
  // program-flow model, and returns at the following negedge+1.
  task automatic drive(input logic s, input logic rv, input logic [31:0] tgt);
    stall           = s;
    redirect_valid  = rv;
    redirect_target = tgt;
    if (rv && !m_halted && !m_idle) begin
      exp_q.delete();
      if (tgt[1:0] != 2'b00) m_halted = 1'b1;
      else exp_q.push_back(tgt);
    end else if (!m_halted && instr_valid && !s) begin
      exp_q.push_back(m_last + 32'd4);
    end
    m_idle = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    exp_q.delete();
    m_halted       = 1'b0;
    #1;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, RV);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_instr_pc", instr_pc, RV);
    check("rst_misalign", {31'b0, misalign_err}, 32'd0);
    repeat (cycles) begin
      @(negedge clk);
      #1;
    end
    rst    = 1'b0;
    m_idle = 1'b1;
    exp_q.push_back(RV);
  endtask

  task automatic run_until_req(input logic [31:0] addr, input string name);
    checks++;
    for (int i = 0; i < 80; i++) begin
      if (imem_req && imem_addr == addr) return;
      drive(1'b0, 1'b0, 32'h0);
    end
    errors++;
    $display("FAIL %s: timeout waiting for request to %h", name, addr);
  endtask

  task automatic wait_valid(input string name);
    checks++;
    for (int i = 0; i < 80; i++) begin
      if (instr_valid) return;
      drive(1'b0, 1'b0, 32'h0);
    end
    errors++;
    $display("FAIL %s: timeout waiting for instr_valid", name);
  endtask

  initial begin
    logic        s;
    logic [31:0] tgt;
    int          r;

    @(negedge clk);
    #1;

    // sequential fetch with a constant instruction word
    const_data  = 1'b1;
    fixed_mode  = 1'b1;
    fixed_delay = 0;
    do_reset(2);
    wait_valid("first_instr");
    check("first_pc", instr_pc, RV);
    check("first_word", instr, 32'h0050_0093);
    repeat (8) drive(1'b0, 1'b0, 32'h0);
    check("gnt_count_ge3", {31'b0, gnt_log.size() >= 3}, 32'd1);
    if (gnt_log.size() >= 3) begin
      check("fetch0_addr", gnt_log[0], 32'h0);
      check("fetch1_addr", gnt_log[1], 32'h4);
      check("fetch2_addr", gnt_log[2], 32'h8);
    end

    // stall holds the instruction; release issues pc+4 one cycle later
    wait_valid("stall_hold");
    repeat (3) begin
      drive(1'b1, 1'b0, 32'h0);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_noreq", {31'b0, imem_req}, 32'd0);
    end
    drive(1'b0, 1'b0, 32'h0);
    check("consume_req", {31'b0, imem_req}, 32'd1);
    check("consume_addr", imem_addr, m_last + 32'd4);

    // redirect in WAIT coinciding with rvalid
    const_data = 1'b0;
    do_reset(1);
    run_until_req(32'h10, "reach_0x10");
    drive(1'b0, 1'b0, 32'h0);
    check("wait_novalid", {31'b0, instr_valid}, 32'd0);
    drive(1'b0, 1'b1, 32'h100);
    check("wait_redir_req", {31'b0, imem_req}, 32'd1);
    check("wait_redir_addr", imem_addr, 32'h100);
    wait_valid("redir_instr");
    check("redir_pc", instr_pc, 32'h100);

    // redirect in REQ while gnt is withheld
    do_reset(1);
    block_en   = 1'b1;
    block_addr = 32'h20;
    run_until_req(32'h20, "reach_0x20");
    drive(1'b0, 1'b0, 32'h0);
    check("blocked_req", {31'b0, imem_req}, 32'd1);
    check("blocked_addr", imem_addr, 32'h20);
    drive(1'b0, 1'b1, 32'h200);
    check("req_redir_req", {31'b0, imem_req}, 32'd1);
    check("req_redir_addr", imem_addr, 32'h200);
    block_en = 1'b0;

    // misaligned redirect halts until reset
    wait_valid("pre_misalign");
    drive(1'b0, 1'b1, 32'h102);
    check("misalign_set", {31'b0, misalign_err}, 32'd1);
    check("misalign_noreq", {31'b0, imem_req}, 32'd0);
    check("misalign_novalid", {31'b0, instr_valid}, 32'd0);
    repeat (4) drive(1'b0, 1'b1, 32'h300);
    check("halt_sticky", {31'b0, misalign_err}, 32'd1);
    do_reset(1);
    drive(1'b0, 1'b0, 32'h0);
    check("post_halt_req", {31'b0, imem_req}, 32'd1);
    check("post_halt_addr", imem_addr, RV);

    // pc wrap, then reset during WAIT with a late response
    wait_valid("pre_wrap");
    drive(1'b0, 1'b1, 32'hFFFF_FFFC);
    wait_valid("wrap_instr");
    check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 32'h0);
    check("wrap_req", {31'b0, imem_req}, 32'd1);
    check("wrap_addr", imem_addr, 32'h0);
    wait_valid("zero_instr");
    fixed_delay = 3;
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    fixed_delay = 0;
    do_reset(1);
    wait_valid("post_stale");
    check("post_stale_pc", instr_pc, RV);

    // randomized traffic against the reference model
    fixed_mode = 1'b0;
    do_reset(1);
    for (int i = 0; i < 1500; i++) begin
      if (m_halted && $urandom_range(0, 3) == 0) begin
        do_reset(int'($urandom_range(1, 2)));
      end else if ($urandom_range(0, 199) == 0) begin
        do_reset(1);
      end else begin
        r = int'($urandom_range(0, 99));
        s = ($urandom_range(0, 99) < 30);
        if (r < 6) begin
          tgt = $urandom_range(0, 1023) << 2;
          drive(s, 1'b1, tgt);
        end else if (r == 6) begin
          tgt = 32'hFFFF_FFF8;
          drive(s, 1'b1, tgt);
        end else if (r == 7) begin
          tgt = ($urandom_range(0, 1023) << 2) | $urandom_range(1, 3);
          drive(s, 1'b1, tgt);
        end else begin
          tgt = $urandom;
          drive(s, 1'b0, tgt);
        end
      end
    end
    repeat (5) drive(1'b0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
